// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer: freezes the pipeline, pulses the multdiv unit, returns one writeback packet.
// Optional BUSY watchdog compiled in with `define MD_TIMEOUT_EN (parameter TIMEOUT).
module md_sequencer #(
`ifdef MD_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 48,
`endif
    parameter logic [31:0] EXC_MULT = 32'd4,
    parameter logic [31:0] EXC_DIV  = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    output logic        stall,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [31:0] busy_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic        div_q, div_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic [31:0] busy_cycles_q, busy_cycles_d;
`ifdef MD_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        div_d    = div_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MD_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    a_d     = issue_a;
                    b_d     = issue_b;
                    rd_d    = issue_rd;
                    div_d   = issue_is_div;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_BUSY;
`ifdef MD_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_BUSY: begin
                if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = S_DONE;
                end
`ifdef MD_TIMEOUT_EN
                // Watchdog abort reports as an exception so the packet lands in $rstatus.
                else if (tmo_q == TIMEOUT - 1) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall = ~reset & (((state_q == S_IDLE) & issue_valid) |
                          (state_q == S_START) | (state_q == S_BUSY));
        busy_cycles_d = busy_cycles_q + {31'b0, stall};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            div_q         <= 1'b0;
            result_q      <= '0;
            exc_q         <= 1'b0;
            busy_cycles_q <= '0;
`ifdef MD_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            div_q         <= div_d;
            result_q      <= result_d;
            exc_q         <= exc_d;
            busy_cycles_q <= busy_cycles_d;
`ifdef MD_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    always_comb begin
        ctrl_MULT   = (state_q == S_START) & ~div_q;
        ctrl_DIV    = (state_q == S_START) & div_q;
        md_a        = a_q;
        md_b        = b_q;
        busy_cycles = busy_cycles_q;
        wb_valid    = (state_q == S_DONE);
        wb_we       = wb_valid & (exc_q | (rd_q != '0));
        wb_reg      = '0;
        wb_data     = '0;
        if (wb_valid) begin
            wb_reg  = exc_q ? 5'd30 : rd_q;
            wb_data = exc_q ? (div_q ? EXC_DIV : EXC_MULT) : result_q;
        end
    end

endmodule
